s13207_sel_pipe: RTL
====================

Name: s13207_sel_pipe

Overview:
- Parametrised, pipelined successor to the s13207 g9280 decoded-select cone.
- Qualifies a request with a select field, a mode field and a gate field, then picks one data word from one of two banks.
- The result is registered, carried over a valid/ready handshake and optionally forced high.
- Saturating hit/miss counters support observation in the fault-injection/ATPG flow.

Parameters:
SEL_W, 4, select field width; each bank has 2**SEL_W channels
DATA_W, 1, width of each channel word and of out_data
MODE_W, 4, mode field width (MODE_W >= 2)
DEFAULT, all-ones, out_data value on a miss (DATA_W bits)
CNT_W, 8, hit/miss counter width

Ports:
CK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
sel  in  SEL_W  channel index
mode  in  MODE_W  bank/mode code
gate  in  5  qualifier, bit order {g55,g42,g45,g41,g44}
force_n  in  1  active-low force; sampled with the request
bank_a  in  DATA_W*2**SEL_W  bank A words; channel k = bits [k*DATA_W +: DATA_W]
bank_b  in  DATA_W*2**SEL_W  bank B words, same packing
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_data  out  DATA_W  result word
out_hit  out  1  1 = result came from a bank
hit_cnt  out  CNT_W  accepted hits, saturating
miss_cnt  out  CNT_W  accepted misses, saturating

Behaviour:
- Reset (RST=1 at edge): all pipe valids=0, out_valid=0, out_data=DEFAULT, out_hit=0, hit_cnt=0, miss_cnt=0. In the RST cycle in_ready=0.
- Reset mid-operation drops all in-flight requests; no counter update.
- stall = out_valid & ~out_ready. in_ready = ~RST & ~stall.
- When stall=1 the whole pipe holds, out_data and out_hit stay stable, and no counter changes.
- Gate qualify: gate_ok = gate[0] & ~|gate[4:1] (g44=1, all others 0).
- Mode decode:
  - mode==0 -> bank B.
  - mode==1 -> bank A.
  - mode all-ones -> miss.
  - Any other code -> miss.
- hit = gate_ok & (mode==0 | mode==1).
- Stage 1, on accept:
  - Register word = selected bank[sel] if hit, else DEFAULT.
  - Register hit and force_n. s1_valid=1.
  - Bank data is sampled only at accept; later bank changes do not affect that request.
- Stage 2, when not stalled:
  - out_valid <= s1_valid.
  - out_data <= force_n ? word : all-ones.
  - out_hit <= hit & force_n. Force overrides a hit and reports out_hit=0.
- Latency: exactly 2 cycles from accept to out_valid with out_ready=1. Throughput is 1 per cycle.
- A bubble in stage 1 propagates as out_valid=0 and leaves out_data at its last value.
- Counters update at accept:
  - hit_cnt+1 if hit, else miss_cnt+1.
  - Both saturate at 2**CNT_W-1, with no wrap.
  - force_n does not affect the counters.
- Simultaneous accept and output consume in one cycle are legal; no data is lost or duplicated.
- If sel is wider than the bank there is no out-of-range case: 2**SEL_W channels are always present.

Test Plan:
- RST=1 for 2 cycles, then idle -> out_valid=0, out_data=1, out_hit=0, counters=0, in_ready=1 after reset.
- Defaults, gate=5'b00001, mode=1, sel=9, bank_a[9]=0, force_n=1, out_ready=1 -> out_valid=1 two cycles later, out_data=0, out_hit=1, hit_cnt=1.
- Same with gate=5'b00011 (g41=1) or mode=4'hF -> out_data=1, out_hit=0, miss_cnt=1, hit_cnt=0.
- mode=0, sel=3, bank_b[3]=0, force_n=0 -> out_data=1, out_hit=0, hit_cnt=1.
- Back-to-back requests sel=0..15 with out_ready=0 for cycles 3-6 -> in_ready=0 while stalled, output held stable, all 16 results in order, none lost.
- CNT_W=2, 5 hits -> hit_cnt saturates at 3.
- RST asserted with 2 requests in flight -> no out_valid follows and counters=0.

Source files
------------

// File: rtl/s13207_sel_pipe.sv
// Two-stage qualified bank-select pipe with valid/ready output handshake,
// active-low force-high and saturating hit/miss observation counters.
module s13207_sel_pipe #(
  parameter int                 SEL_W   = 4,
  parameter int                 DATA_W  = 1,
  parameter int                 MODE_W  = 4,
  parameter logic [DATA_W-1:0]  DEFAULT = '1,
  parameter int                 CNT_W   = 8
) (
  input  logic                        CK,
  input  logic                        RST,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SEL_W-1:0]            sel,
  input  logic [MODE_W-1:0]           mode,
  input  logic [4:0]                  gate,
  input  logic                        force_n,
  input  logic [DATA_W*(2**SEL_W)-1:0] bank_a,
  input  logic [DATA_W*(2**SEL_W)-1:0] bank_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_hit,
  output logic [CNT_W-1:0]            hit_cnt,
  output logic [CNT_W-1:0]            miss_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                 w_stall;
  logic                 w_accept;
  logic                 w_gate_ok;
  logic                 w_mode_a;
  logic                 w_mode_b;
  logic                 w_hit;
  logic [DATA_W-1:0]    w_word_a;
  logic [DATA_W-1:0]    w_word_b;
  logic [DATA_W-1:0]    w_word;

  logic                 r_s1_valid;
  logic [DATA_W-1:0]    r_s1_word;
  logic                 r_s1_hit;
  logic                 r_s1_force_n;
  logic                 r_out_valid;
  logic [DATA_W-1:0]    r_out_data;
  logic                 r_out_hit;
  logic [CNT_W-1:0]     r_hit_cnt;
  logic [CNT_W-1:0]     r_miss_cnt;

  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~RST & ~w_stall;
  assign w_accept = in_valid & in_ready;

  // Only g44 may be set; any of g55/g42/g45/g41 disqualifies the request.
  assign w_gate_ok = gate[0] & ~|gate[4:1];
  assign w_mode_b  = (mode == '0);
  assign w_mode_a  = (mode == MODE_W'(1));
  assign w_hit     = w_gate_ok & (w_mode_a | w_mode_b);

  assign w_word_a = bank_a[int'(sel)*DATA_W +: DATA_W];
  assign w_word_b = bank_b[int'(sel)*DATA_W +: DATA_W];
  assign w_word   = !w_hit   ? DEFAULT  :
                    w_mode_a ? w_word_a : w_word_b;

  always_ff @(posedge CK) begin
    if (RST) begin
      r_s1_valid   <= 1'b0;
      r_s1_word    <= DEFAULT;
      r_s1_hit     <= 1'b0;
      r_s1_force_n <= 1'b1;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_word    <= w_word;
        r_s1_hit     <= w_hit;
        r_s1_force_n <= force_n;
      end
    end
  end

  // A stage-1 bubble clears out_valid but keeps the last presented word.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_out_data  <= DEFAULT;
      r_out_hit   <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= r_s1_force_n ? r_s1_word : '1;
        r_out_hit  <= r_s1_hit & r_s1_force_n;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_hit) begin
        if (r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end else begin
        if (r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_hit   = r_out_hit;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule
